// File: rtl/clk_div_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : clk_div_pkg                                               |
// | Purpose  : Shared constants and types for the clock-divider bank.    |
// |            CLK_DIV_MAX_CH : upper bound on the number of channels    |
// |            CLK_DIV_CNT_W  : default half-period width                |
// |            div_t          : half-period value at the default width   |
// |            div_off        : half-period value that disables a channel|
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
package clk_div_pkg;

  localparam int CLK_DIV_MAX_CH = 8;
  localparam int CLK_DIV_CNT_W  = 8;

  typedef logic [CLK_DIV_CNT_W-1:0] div_t;

  localparam div_t div_off = '0;

endpackage
`default_nettype wire

// File: rtl/clk_div_channel.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : clk_div_channel                                           |
// | Purpose  : One divider channel: half-period register H, counter,     |
// |            registered 50 %-duty output and rise tick.                |
// | Ports    : clk_in      - source clock (rising edge only)             |
// |            reset       - asynchronous active-high reset              |
// |            i_sync      - realign: counter and output cleared         |
// |            i_load      - apply i_load_div as the new H               |
// |            i_load_div  - new half-period (0 = disabled)              |
// |            o_clk       - divided clock                               |
// |            o_tick      - one-cycle pulse in the cycle after a rise   |
// |            o_boundary  - this edge is a period boundary              |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
module clk_div_channel
  import clk_div_pkg::*;
#(
  parameter int               CNT_W = CLK_DIV_CNT_W,
  parameter logic [CNT_W-1:0] RST_H = CNT_W'(1)
) (
  input  logic             clk_in,
  input  logic             reset,
  input  logic             i_sync,
  input  logic             i_load,
  input  logic [CNT_W-1:0] i_load_div,
  output logic             o_clk,
  output logic             o_tick,
  output logic             o_boundary
);

  logic [CNT_W-1:0] r_h;
  logic [CNT_W-1:0] r_cnt;
  logic             r_out;
  logic             r_tick;

  logic w_en;
  logic w_wrap;
  logic w_load_en;

  assign w_en      = (r_h != CNT_W'(div_off));
  assign w_wrap    = (r_cnt == (r_h - CNT_W'(1)));
  assign w_load_en = (i_load_div != CNT_W'(div_off));

  // The boundary is the edge on which the output would rise; a disabled
  // channel has no phase to protect, so every edge qualifies.
  assign o_boundary = ~w_en | (w_wrap & ~r_out);

  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      r_h    <= RST_H;
      r_cnt  <= '0;
      r_out  <= 1'b0;
      r_tick <= 1'b0;
    end else if (i_sync) begin
      r_cnt  <= '0;
      r_out  <= 1'b0;
      r_tick <= 1'b0;
      if (i_load) begin
        r_h <= i_load_div;
      end
    end else if (i_load) begin
      // Loads only arrive at a boundary, so an enabled channel was about
      // to rise anyway; a channel coming out of disable starts low.
      r_h    <= i_load_div;
      r_cnt  <= '0;
      r_out  <= w_load_en & w_en;
      r_tick <= w_load_en & w_en;
    end else if (!w_en) begin
      r_cnt  <= '0;
      r_out  <= 1'b0;
      r_tick <= 1'b0;
    end else if (w_wrap) begin
      r_cnt  <= '0;
      r_out  <= ~r_out;
      r_tick <= ~r_out;
    end else begin
      r_cnt  <= r_cnt + CNT_W'(1);
      r_tick <= 1'b0;
    end
  end

  assign o_clk  = r_out;
  assign o_tick = r_tick;

endmodule
`default_nettype wire

// File: rtl/clk_div_bank.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : clk_div_bank                                              |
// | Purpose  : Bank of NUM_CH independent 50 %-duty clock dividers with  |
// |            a single-slot valid/ready reconfiguration port. A new     |
// |            half-period is applied at the target channel's next       |
// |            period boundary, so outputs never glitch.                 |
// | Ports    : clk_in    - source clock                                  |
// |            reset     - asynchronous active-high reset                |
// |            cfg_valid - configuration request                         |
// |            cfg_ready - configuration slot free                       |
// |            cfg_ch    - target channel (out-of-range is discarded)    |
// |            cfg_div   - new half-period H (0 disables the channel)    |
// |            sync_req  - phase realignment (CLK_DIV_SYNC_EN only)      |
// |            clk_out   - divided clocks                                |
// |            tick_out  - one-cycle pulses following each rise          |
// | Macro    : CLK_DIV_SYNC_EN adds sync_req                             |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
module clk_div_bank
  import clk_div_pkg::*;
#(
  parameter int                      NUM_CH    = 2,
  parameter int                      CNT_W     = CLK_DIV_CNT_W,
  parameter logic [NUM_CH*CNT_W-1:0] RESET_DIV = {8'd1, 8'd2},
  localparam int                     CH_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk_in,
  input  logic              reset,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [CNT_W-1:0]  cfg_div,
`ifdef CLK_DIV_SYNC_EN
  input  logic              sync_req,
`endif
  output logic [NUM_CH-1:0] clk_out,
  output logic [NUM_CH-1:0] tick_out
);

  logic              r_pend_vld;
  logic [CH_W-1:0]   r_pend_ch;
  logic [CNT_W-1:0]  r_pend_div;

  logic              w_sync;
  logic              w_accept;
  logic              w_ch_ok;
  logic              w_apply;
  logic [NUM_CH-1:0] w_sel;
  logic [NUM_CH-1:0] w_boundary;
  logic [NUM_CH-1:0] w_load;

`ifdef CLK_DIV_SYNC_EN
  assign w_sync = sync_req;
`else
  assign w_sync = 1'b0;
`endif

  assign cfg_ready = ~r_pend_vld;
  assign w_accept  = cfg_valid & ~r_pend_vld;
  assign w_ch_ok   = (32'(cfg_ch) < NUM_CH);

  // The slot is only ever filled after the accepting edge, so applying
  // whenever it is valid is automatically strictly after acceptance.
  // A realignment forces the pending value in at the same edge.
  assign w_apply = r_pend_vld & (w_sync | (|(w_sel & w_boundary)));

  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      r_pend_vld <= 1'b0;
      r_pend_ch  <= '0;
      r_pend_div <= '0;
    end else if (w_apply) begin
      r_pend_vld <= 1'b0;
    end else if (w_accept && w_ch_ok) begin
      r_pend_vld <= 1'b1;
      r_pend_ch  <= cfg_ch;
      r_pend_div <= cfg_div;
    end
  end

  generate
    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
      assign w_sel[i]  = (r_pend_ch == CH_W'(i));
      assign w_load[i] = w_apply & w_sel[i];

      clk_div_channel #(
        .CNT_W (CNT_W),
        .RST_H (RESET_DIV[i*CNT_W +: CNT_W])
      ) u_channel (
        .clk_in     (clk_in),
        .reset      (reset),
        .i_sync     (w_sync),
        .i_load     (w_load[i]),
        .i_load_div (r_pend_div),
        .o_clk      (clk_out[i]),
        .o_tick     (tick_out[i]),
        .o_boundary (w_boundary[i])
      );
    end
  endgenerate

endmodule
`default_nettype wire

// File: tb/tb_clk_div_bank.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : tb_clk_div_bank                                           |
// | Purpose  : Self-checking bench for clk_div_bank (3 channels, so an   |
// |            out-of-range channel code exists). Expected outputs come  |
// |            from a timeline model: each enabled channel rises at      |
// |            anchor + k*2H and is high for H edges after each rise.    |
// | Macro    : CLK_DIV_SYNC_EN enables the realignment scenario          |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
module tb_clk_div_bank;

  logic       clk_in;
  logic       reset;
  logic       cfg_valid;
  logic       cfg_ready;
  logic [1:0] cfg_ch;
  logic [7:0] cfg_div;
`ifdef CLK_DIV_SYNC_EN
  logic       sync_req;
`endif
  logic [2:0] clk_out;
  logic [2:0] tick_out;

  int errors;
  int checks;

  // Reference model: edge index n since reset release, per-channel H and
  // the edge number of a (possibly virtual) rise that anchors the phase.
  int n;
  int m_h[3];
  int m_anc[3];
  bit m_pv;
  int m_pch;
  int m_pdiv;

  clk_div_bank #(
    .NUM_CH    (3),
    .CNT_W     (8),
    .RESET_DIV ({8'd3, 8'd1, 8'd2})
  ) dut (
    .clk_in    (clk_in),
    .reset     (reset),
    .cfg_valid (cfg_valid),
    .cfg_ready (cfg_ready),
    .cfg_ch    (cfg_ch),
    .cfg_div   (cfg_div),
`ifdef CLK_DIV_SYNC_EN
    .sync_req  (sync_req),
`endif
    .clk_out   (clk_out),
    .tick_out  (tick_out)
  );

  initial begin
    clk_in = 1'b0;
    forever #5 clk_in = ~clk_in;
  end

  function automatic int phase(int c);
    int p;
    p = 2 * m_h[c];
    return (((n - m_anc[c]) % p) + p) % p;
  endfunction

  function automatic logic [6:0] exp_vec();
    logic [2:0] o;
    logic [2:0] t;
    for (int c = 0; c < 3; c++) begin
      o[c] = 1'b0;
      t[c] = 1'b0;
      if (m_h[c] != 0) begin
        o[c] = (phase(c) < m_h[c]);
        t[c] = (phase(c) == 0);
      end
    end
    return {o, t, ~m_pv};
  endfunction

  task automatic model_reset();
    n        = 0;
    m_h[0]   = 2;
    m_h[1]   = 1;
    m_h[2]   = 3;
    for (int c = 0; c < 3; c++) m_anc[c] = -m_h[c];
    m_pv     = 1'b0;
    m_pch    = 0;
    m_pdiv   = 0;
  endtask

  // Advance one rising edge and update the model from the inputs seen there.
  task automatic cycle();
    bit acc;
    bit do_sync;
    int a_ch;
    int a_div;
    @(posedge clk_in);
    acc     = cfg_valid && !m_pv;
    a_ch    = int'(cfg_ch);
    a_div   = int'(cfg_div);
    do_sync = 1'b0;
`ifdef CLK_DIV_SYNC_EN
    do_sync = sync_req;
`endif
    n++;
    if (do_sync) begin
      for (int c = 0; c < 3; c++) if (m_h[c] != 0) m_anc[c] = n - m_h[c];
      if (m_pv) begin
        m_h[m_pch]   = m_pdiv;
        m_anc[m_pch] = n - m_pdiv;
        m_pv         = 1'b0;
      end
    end else if (m_pv && (m_h[m_pch] == 0 || phase(m_pch) == 0)) begin
      if (m_pdiv == 0) begin
        m_h[m_pch] = 0;
      end else if (m_h[m_pch] == 0) begin
        m_h[m_pch]   = m_pdiv;
        m_anc[m_pch] = n - m_pdiv;
      end else begin
        m_h[m_pch]   = m_pdiv;
        m_anc[m_pch] = n;
      end
      m_pv = 1'b0;
    end
    if (acc && a_ch < 3) begin
      m_pv   = 1'b1;
      m_pch  = a_ch;
      m_pdiv = a_div;
    end
    #1;
  endtask

  // Hold a request until the model accepts it (bounded), checking each edge.
  task automatic send_cfg(input int ch, input int div, input string name);
    int k;
    k = 0;
    while (m_pv && k < 40) begin
      cycle();
      checks++;
      if ({clk_out, tick_out, cfg_ready} !== exp_vec()) begin
        errors++;
        $display("FAIL %s_wait n=%0d got=%b exp=%b", name, n, {clk_out, tick_out, cfg_ready}, exp_vec());
      end
      k++;
    end
    checks++;
    if (m_pv) begin
      errors++;
      $display("FAIL %s_timeout slot still busy after %0d edges", name, k);
    end
    cfg_valid = 1'b1;
    cfg_ch    = 2'(ch);
    cfg_div   = 8'(div);
    cycle();
    cfg_valid = 1'b0;
    checks++;
    if ({clk_out, tick_out, cfg_ready} !== exp_vec()) begin
      errors++;
      $display("FAIL %s_accept n=%0d got=%b exp=%b", name, n, {clk_out, tick_out, cfg_ready}, exp_vec());
    end
  endtask

  task automatic wait_ch0_rise(input string name);
    bit seen;
    seen = 1'b0;
    for (int k = 0; k < 16 && !seen; k++) begin
      cycle();
      checks++;
      if ({clk_out, tick_out, cfg_ready} !== exp_vec()) begin
        errors++;
        $display("FAIL %s_rise n=%0d got=%b exp=%b", name, n, {clk_out, tick_out, cfg_ready}, exp_vec());
      end
      seen = (m_h[0] != 0) && (phase(0) == 0);
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL %s_rise_timeout no ch0 rise within 16 edges", name);
    end
  endtask

  task automatic test_reset();
    cfg_valid = 1'b0;
    cfg_ch    = '0;
    cfg_div   = '0;
    reset     = 1'b1;
    model_reset();
    #3;
    checks++;
    if ({clk_out, tick_out, cfg_ready} !== 7'b0000001) begin
      errors++;
      $display("FAIL reset_assert got=%b exp=%b", {clk_out, tick_out, cfg_ready}, 7'b0000001);
    end
    repeat (3) @(posedge clk_in);
    #1;
    checks++;
    if ({clk_out, tick_out, cfg_ready} !== 7'b0000001) begin
      errors++;
      $display("FAIL reset_hold got=%b exp=%b", {clk_out, tick_out, cfg_ready}, 7'b0000001);
    end
    @(negedge clk_in);
    reset = 1'b0;
  endtask

  task automatic test_default_periods(input string name);
    for (int k = 0; k < 16; k++) begin
      cycle();
      checks++;
      if ({clk_out, tick_out, cfg_ready} !== exp_vec()) begin
        errors++;
        $display("FAIL %s n=%0d got=%b exp=%b", name, n, {clk_out, tick_out, cfg_ready}, exp_vec());
      end
    end
  endtask

  task automatic test_cfg_high_half();
    wait_ch0_rise("high_half");
    send_cfg(0, 3, "high_half");
    for (int k = 0; k < 24; k++) begin
      cycle();
      checks++;
      if ({clk_out, tick_out, cfg_ready} !== exp_vec()) begin
        errors++;
        $display("FAIL high_half n=%0d got=%b exp=%b", n, {clk_out, tick_out, cfg_ready}, exp_vec());
      end
    end
  endtask

  task automatic test_disable_enable();
    send_cfg(1, 0, "disable");
    for (int k = 0; k < 6; k++) begin
      cycle();
      checks++;
      if ({clk_out, tick_out, cfg_ready} !== exp_vec()) begin
        errors++;
        $display("FAIL disable n=%0d got=%b exp=%b", n, {clk_out, tick_out, cfg_ready}, exp_vec());
      end
    end
    send_cfg(1, 1, "enable");
    for (int k = 0; k < 8; k++) begin
      cycle();
      checks++;
      if ({clk_out, tick_out, cfg_ready} !== exp_vec()) begin
        errors++;
        $display("FAIL enable n=%0d got=%b exp=%b", n, {clk_out, tick_out, cfg_ready}, exp_vec());
      end
    end
  endtask

  task automatic test_out_of_range();
    send_cfg(3, 7, "bad_ch");
    for (int k = 0; k < 8; k++) begin
      cycle();
      checks++;
      if ({clk_out, tick_out, cfg_ready} !== exp_vec()) begin
        errors++;
        $display("FAIL bad_ch n=%0d got=%b exp=%b", n, {clk_out, tick_out, cfg_ready}, exp_vec());
      end
    end
  endtask

  task automatic test_async_reset();
    wait_ch0_rise("async_rst");
    send_cfg(0, 5, "async_rst");
    #2;
    reset = 1'b1;
    model_reset();
    #1;
    checks++;
    if ({clk_out, tick_out, cfg_ready} !== 7'b0000001) begin
      errors++;
      $display("FAIL async_rst_drop got=%b exp=%b", {clk_out, tick_out, cfg_ready}, 7'b0000001);
    end
    @(negedge clk_in);
    reset = 1'b0;
    test_default_periods("after_async_rst");
  endtask

  task automatic test_random();
    for (int k = 0; k < 400; k++) begin
      cfg_valid = ($urandom_range(0, 3) == 0);
      cfg_ch    = 2'($urandom_range(0, 3));
      cfg_div   = 8'($urandom_range(0, 5));
`ifdef CLK_DIV_SYNC_EN
      sync_req  = ($urandom_range(0, 19) == 0);
`endif
      cycle();
      checks++;
      if ({clk_out, tick_out, cfg_ready} !== exp_vec()) begin
        errors++;
        $display("FAIL random n=%0d got=%b exp=%b", n, {clk_out, tick_out, cfg_ready}, exp_vec());
      end
    end
    cfg_valid = 1'b0;
`ifdef CLK_DIV_SYNC_EN
    sync_req  = 1'b0;
`endif
  endtask

`ifdef CLK_DIV_SYNC_EN
  task automatic test_sync();
    send_cfg(0, 2, "sync_cfg0");
    send_cfg(1, 4, "sync_cfg1");
    send_cfg(2, 3, "sync_cfg2");
    for (int k = 0; k < 5; k++) begin
      cycle();
      checks++;
      if ({clk_out, tick_out, cfg_ready} !== exp_vec()) begin
        errors++;
        $display("FAIL sync_pre n=%0d got=%b exp=%b", n, {clk_out, tick_out, cfg_ready}, exp_vec());
      end
    end
    sync_req = 1'b1;
    cycle();
    sync_req = 1'b0;
    checks++;
    if ({clk_out[1:0], tick_out[1:0]} !== 4'b0000) begin
      errors++;
      $display("FAIL sync_clear got=%b exp=%b", {clk_out[1:0], tick_out[1:0]}, 4'b0000);
    end
    for (int k = 0; k < 24; k++) begin
      cycle();
      checks++;
      if ({clk_out, tick_out, cfg_ready} !== exp_vec()) begin
        errors++;
        $display("FAIL sync_post n=%0d got=%b exp=%b", n, {clk_out, tick_out, cfg_ready}, exp_vec());
      end
    end
  endtask
`endif

  initial begin
    errors    = 0;
    checks    = 0;
    reset     = 1'b0;
    cfg_valid = 1'b0;
    cfg_ch    = '0;
    cfg_div   = '0;
`ifdef CLK_DIV_SYNC_EN
    sync_req  = 1'b0;
`endif
    #2;
    test_reset();
    test_default_periods("default_periods");
    test_cfg_high_half();
    test_disable_enable();
    test_out_of_range();
    test_async_reset();
    test_random();
`ifdef CLK_DIV_SYNC_EN
    test_sync();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
